// File: rtl/weighted_rr_arbiter.sv
// ---------------------------------------------------------------------------
// weighted_rr_arbiter
//   Round-robin arbiter for N requesters. Each grant is a tenure whose length
//   is capped by the winner's weight, counted in cycles. A weight of 0 counts
//   as 1. A tenure ends early when the owner drops its request. Another
//   requester can never preempt a running tenure. After every grant the
//   rotation pointer moves past the winner.
//
//   Optional feature (macro ARB_URGENT_EN): this adds the port urgent. At each
//   arbitration point, requesters with req & urgent are searched first, using
//   the same rotation. The remaining requesters are searched after them.
//
// Ports
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-low reset
//   urgent  in   N bits, only with ARB_URGENT_EN: urgent qualifier per requester
//   req     in   N bits, level request per requester
//   weight  in   N*WW bits, field i = weight[i*WW +: WW] = max tenure of req i
//   grant   out  N bits, registered, one-hot or zero
//   owner   out  2 bits, index of granted requester (0 when idle)
//   busy    out  1 when grant is non-zero
// ---------------------------------------------------------------------------
module weighted_rr_arbiter #(
    parameter int N  = 4,
    parameter int WW = 4
) (
    input  logic            clk,
    input  logic            rst,
`ifdef ARB_URGENT_EN
    input  logic [N-1:0]    urgent,
`endif
    input  logic [N-1:0]    req,
    input  logic [N*WW-1:0] weight,
    output logic [N-1:0]    grant,
    output logic [1:0]      owner,
    output logic            busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [WW-1:0] ONE = {{(WW-1){1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [1:0]      owner_q, owner_d;
    logic [1:0]      ptr_q,   ptr_d;
    logic [WW-1:0]   cnt_q,   cnt_d;

    logic [N-1:0]    cand;
    logic [1:0]      idx;
    logic            win_found;
    logic [1:0]      win_idx;
    logic [WW-1:0]   wsel;
    logic            tenure_end;
    logic            arb;

    // Winner search: first set bit of cand, starting at ptr and wrapping.
    // The current owner is last in the rotation. If it is the only one still
    // requesting, the search lands on it again and its tenure restarts.
    always_comb begin
        cand = req;
`ifdef ARB_URGENT_EN
        if (|(req & urgent)) begin
            cand = req & urgent;
        end
`endif
        idx       = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = ptr_q + 2'(i);
            if (!win_found && cand[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    always_comb begin
        wsel = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (win_idx == 2'(i)) begin
                wsel = weight[i*WW +: WW];
            end
        end
    end

    assign tenure_end = (state_q == GRANT) && (!req[owner_q] || cnt_q == ONE);
    assign arb        = ((state_q == IDLE) && (|req)) || tenure_end;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (arb) begin
            if (win_found) begin
                state_d          = GRANT;
                grant_d          = '0;
                grant_d[win_idx] = 1'b1;
                owner_d          = win_idx;
                cnt_d            = (wsel == '0) ? ONE : wsel;
                ptr_d            = win_idx + 2'd1;
            end else begin
                state_d = IDLE;
                grant_d = '0;
                owner_d = '0;
                cnt_d   = '0;
            end
        end else if (state_q == GRANT) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant = grant_q;
    assign owner = owner_q;
    assign busy  = |grant_q;

endmodule

// File: doc/weighted_rr_arbiter.md
WEIGHTED_RR_ARBITER -- requirements
Module: weighted_rr_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the number of requesters; the legal value is 4.
REQ-002 The block SHALL have parameter WW, default 4, meaning the width of each per-requester weight field.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port req, input, N bits: request per requester, level-sensitive, sampled on the rising clk edge.
REQ-006 The block SHALL have port weight, input, N*WW bits: field i, bits [i*WW +: WW], is the maximum tenure length of requester i in cycles.
REQ-007 The block SHALL have port grant, output, N bits: registered, one-hot or zero.
REQ-008 The block SHALL have port owner, output, 2 bits: index of the granted requester; 0 when grant is zero.
REQ-009 The block SHALL have port busy, output, 1 bit: 1 exactly when grant is non-zero.

Function
REQ-010 The block SHALL implement states IDLE (no grant) and GRANT (one tenure in progress).
REQ-011 An arbitration point SHALL be either a clock edge in IDLE with req non-zero, or the last cycle of a tenure; the winner is the first requester with req=1, searching from ptr upward and wrapping N-1 -> 0.
REQ-012 Latency: grant SHALL assert on the first rising edge after req is sampled high in IDLE, so there is one cycle from req to grant.
REQ-013 At tenure start the block SHALL load a tenure counter with weight[owner]; weight 0 SHALL be treated as 1; weight changes during a tenure SHALL have no effect.
REQ-014 The counter SHALL decrement once per granted cycle; the tenure ends on the cycle where req[owner] is sampled 0 or the counter equals 1.
REQ-015 At tenure end, if another requester is pending, grant SHALL move directly to the next winner on the following edge with no idle cycle.
REQ-016 At tenure end, if only the current owner still requests, the block SHALL start a new tenure for the same owner and reload the counter.
REQ-017 At tenure end with no pending req, the block SHALL clear grant and return to IDLE.
REQ-018 On every grant, ptr SHALL be set to winner+1 mod N, so the last winner always has lowest priority at the next arbitration.
REQ-019 Requests from non-owners during a tenure SHALL never preempt the owner.
REQ-020 If req[owner] drops with counter > 1, the tenure SHALL end at that edge, with no residual grant cycles.
REQ-021 grant SHALL never be multi-hot, and SHALL never be asserted to a requester whose req was 0 at the arbitration edge.

Reset
REQ-022 While rst=0: grant=0, owner=0, busy=0, state=IDLE, ptr=0, counter=0, all asynchronously.
REQ-023 Reset assertion mid-tenure SHALL drop grant immediately, with no completion of the tenure.
REQ-024 After rst deasserts, the first arbitration SHALL start its search from requester 0.

Configuration
REQ-025 Macro ARB_URGENT_EN: when defined, the block SHALL add port urgent, input, N bits.
REQ-026 With ARB_URGENT_EN defined, at each arbitration point requesters with req&urgent SHALL be searched first (same rotation from ptr), then the rest; urgent SHALL never preempt a running tenure.
REQ-027 With ARB_URGENT_EN not defined, the urgent port SHALL be absent and arbitration SHALL be pure weighted round-robin per REQ-011.

Verification
REQ-028 Reset release, all weights=1, req=4'b1111 held -> grant sequence 0001,0010,0100,1000,0001 on consecutive cycles, busy=1 throughout.
REQ-029 Weights {w3..w0}={1,1,1,3}, req=4'b1111 -> grant=0001 for 3 cycles, then 0010, 0100, 1000 for 1 cycle each, then 0001 again.
REQ-030 Weight0=4, req=4'b0001 held -> grant=0001 continuously with counter reloading every 4 cycles; req drops -> grant=0000 and busy=0 on the next edge.
REQ-031 Owner 2 with weight 5, req[2] dropped after 2 cycles while req=4'b1001 -> grant=1000 on the next edge, then 0001.
REQ-032 rst pulsed low mid-tenure with grant=0100 -> grant=0000 immediately; after release with req=4'b0110 -> grant=0010.
REQ-033 With ARB_URGENT_EN defined: owner 0, req=4'b1110, urgent=4'b1000 at tenure end -> grant=1000 next, ahead of requesters 1 and 2.
